// File: rtl/swd_xfer_seq.sv
// SWD transfer sequencer: issues one request to the SWD engine, retries on
// WAIT, and reports a classified result through a valid/ready handshake.
module swd_xfer_seq #(
    parameter int RETRY_W = 8,
    parameter int WDT     = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_apndp,
    input  logic               cmd_rnw,
    input  logic [1:0]         cmd_addr32,
    input  logic [31:0]        cmd_wdata,
    input  logic [RETRY_W-1:0] wait_retry,
    input  logic               abort,
    output logic               go,
    output logic               apndp,
    output logic               rnw,
    output logic [1:0]         addr32,
    output logic [31:0]        dwrite,
    input  logic [2:0]         ack,
    input  logic [31:0]        dread,
    input  logic               perr,
    input  logic               idle,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2:0]         res_status,
    output logic [2:0]         res_ack,
    output logic [31:0]        res_data,
    output logic [RETRY_W-1:0] res_tries
);

    localparam int WDT_W = $clog2(WDT + 1);

    localparam logic [2:0] ST_OK    = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_FAULT = 3'd2;
    localparam logic [2:0] ST_NOACK = 3'd3;
    localparam logic [2:0] ST_PERR  = 3'd4;
    localparam logic [2:0] ST_TMO   = 3'd5;
    localparam logic [2:0] ST_ABORT = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_EVAL,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic               apndp_q, apndp_d;
    logic               rnw_q, rnw_d;
    logic [1:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [RETRY_W-1:0] wretry_q, wretry_d;
    logic [RETRY_W-1:0] tries_q, tries_d;
    logic [WDT_W-1:0]   wdt_q, wdt_d;
    logic               pend_q, pend_d;
    logic [2:0]         status_q, status_d;
    logic [2:0]         rack_q, rack_d;
    logic [31:0]        rdata_q, rdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            apndp_q  <= 1'b0;
            rnw_q    <= 1'b0;
            addr_q   <= 2'b00;
            wdata_q  <= 32'h0;
            wretry_q <= '0;
            tries_q  <= '0;
            wdt_q    <= '0;
            pend_q   <= 1'b0;
            status_q <= 3'd0;
            rack_q   <= 3'd0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            apndp_q  <= apndp_d;
            rnw_q    <= rnw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wretry_q <= wretry_d;
            tries_q  <= tries_d;
            wdt_q    <= wdt_d;
            pend_q   <= pend_d;
            status_q <= status_d;
            rack_q   <= rack_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        apndp_d  = apndp_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wretry_d = wretry_q;
        tries_d  = tries_q;
        wdt_d    = wdt_q;
        pend_d   = pend_q;
        status_d = status_q;
        rack_d   = rack_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    apndp_d  = cmd_apndp;
                    rnw_d    = cmd_rnw;
                    addr_d   = cmd_addr32;
                    wdata_d  = cmd_wdata;
                    wretry_d = wait_retry;
                    tries_d  = '0;
                    wdt_d    = '0;
                    pend_d   = 1'b0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Abort wins over an engine that starts in the same cycle
                if (abort) begin
                    status_d = ST_ABORT;
                    rack_d   = 3'd0;
                    rdata_d  = 32'h0;
                    state_d  = S_RESP;
                end else if (!idle) begin
                    state_d = S_BUSY;
                end else if (wdt_q == WDT_W'(WDT - 1)) begin
                    status_d = ST_TMO;
                    rack_d   = 3'd0;
                    rdata_d  = 32'h0;
                    state_d  = S_RESP;
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
            end
            S_BUSY: begin
                if (abort) pend_d = 1'b1;
                if (idle) state_d = S_EVAL;
            end
            S_EVAL: begin
                rack_d  = ack;
                rdata_d = 32'h0;
                state_d = S_RESP;
                unique case (ack)
                    3'b001: begin
                        if (rnw_q) rdata_d = dread;
                        status_d = (rnw_q && perr) ? ST_PERR : ST_OK;
                    end
                    3'b010: begin
                        if (pend_q) begin
                            status_d = ST_ABORT;
                        end else if (tries_q < wretry_q) begin
                            tries_d = tries_q + RETRY_W'(1);
                            wdt_d   = '0;
                            state_d = S_ISSUE;
                        end else begin
                            status_d = ST_WAIT;
                        end
                    end
                    3'b100:  status_d = ST_FAULT;
                    default: status_d = ST_NOACK;
                endcase
            end
            S_RESP: begin
                if (res_ready) begin
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign go         = (state_q == S_ISSUE);
    assign res_valid  = (state_q == S_RESP);
    assign apndp      = apndp_q;
    assign rnw        = rnw_q;
    assign addr32     = addr_q;
    assign dwrite     = wdata_q;
    assign res_status = status_q;
    assign res_ack    = rack_q;
    assign res_data   = rdata_q;
    assign res_tries  = tries_q;

endmodule

// File: tb/tb_swd_xfer_seq.sv
// Directed bench for swd_xfer_seq: a small engine model answers go requests
// with scripted ack/data, and each scenario checks the reported result.
module tb_swd_xfer_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_apndp = 1'b0;
    logic        cmd_rnw = 1'b0;
    logic [1:0]  cmd_addr32 = 2'b00;
    logic [31:0] cmd_wdata = 32'h0;
    logic [7:0]  wait_retry = 8'd0;
    logic        abort = 1'b0;
    logic        go;
    logic        apndp;
    logic        rnw;
    logic [1:0]  addr32;
    logic [31:0] dwrite;
    logic [2:0]  ack = 3'b000;
    logic [31:0] dread = 32'h0;
    logic        perr = 1'b0;
    logic        idle = 1'b1;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [2:0]  res_status;
    logic [2:0]  res_ack;
    logic [31:0] res_data;
    logic [7:0]  res_tries;

    int vecs = 0;
    int errs = 0;
    int go_rises = 0;
    logic go_prev = 1'b0;

    swd_xfer_seq #(.RETRY_W(8), .WDT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_apndp(cmd_apndp), .cmd_rnw(cmd_rnw),
        .cmd_addr32(cmd_addr32), .cmd_wdata(cmd_wdata),
        .wait_retry(wait_retry), .abort(abort),
        .go(go), .apndp(apndp), .rnw(rnw), .addr32(addr32),
        .dwrite(dwrite), .ack(ack), .dread(dread), .perr(perr),
        .idle(idle), .res_valid(res_valid), .res_ready(res_ready),
        .res_status(res_status), .res_ack(res_ack),
        .res_data(res_data), .res_tries(res_tries)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (go && !go_prev) go_rises++;
        go_prev = go;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic ap, input logic rn,
                            input logic [1:0] a, input logic [31:0] wd,
                            input logic [7:0] wr);
        cmd_apndp  = ap;
        cmd_rnw    = rn;
        cmd_addr32 = a;
        cmd_wdata  = wd;
        wait_retry = wr;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic engine(input logic [2:0] a, input logic [31:0] d,
                          input logic pe, input bit ab);
        int n = 0;
        while (!go && n < 50) begin
            tick();
            n++;
        end
        vecs++;
        if (go !== 1'b1) begin
            errs++;
            $display("FAIL engine_go: go=%b required 1", go);
            return;
        end
        idle = 1'b0;
        tick();
        if (ab) abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        ack   = a;
        dread = d;
        perr  = pe;
        idle  = 1'b1;
        tick();
        tick();
    endtask

    task automatic ack_resp();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        vecs++;
        if ({cmd_ready, go, res_valid} !== 3'b100) begin
            errs++;
            $display("FAIL rst_hs: rdy/go/val=%b required 100",
                     {cmd_ready, go, res_valid});
        end
        vecs++;
        if ({res_status, res_ack, res_tries} !== 14'h0) begin
            errs++;
            $display("FAIL rst_res: st=%0d ack=%b tries=%0d required 0",
                     res_status, res_ack, res_tries);
        end
        vecs++;
        if ({res_data, dwrite, apndp, rnw, addr32} !== 68'h0) begin
            errs++;
            $display("FAIL rst_fields: data=%h dw=%h required 0",
                     res_data, dwrite);
        end
    endtask

    task automatic test_read_ok();
        send_cmd(1'b1, 1'b1, 2'b01, 32'h0, 8'd0);
        vecs++;
        if ({go, apndp, rnw, addr32, cmd_ready} !== 6'b111010) begin
            errs++;
            $display("FAIL rd_req: go/ap/rnw/a/rdy=%b required 111010",
                     {go, apndp, rnw, addr32, cmd_ready});
        end
        engine(3'b001, 32'hDEADBEEF, 1'b0, 1'b0);
        vecs++;
        if ({res_valid, res_status, res_ack, res_tries} !== {1'b1, 3'd0, 3'b001, 8'd0}) begin
            errs++;
            $display("FAIL rd_res: val=%b st=%0d ack=%b tries=%0d required 1 0 001 0",
                     res_valid, res_status, res_ack, res_tries);
        end
        vecs++;
        if (res_data !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL rd_data: got %h required deadbeef", res_data);
        end
        ack_resp();
        vecs++;
        if ({cmd_ready, res_valid} !== 2'b10) begin
            errs++;
            $display("FAIL rd_done: rdy/val=%b required 10",
                     {cmd_ready, res_valid});
        end
    endtask

    task automatic test_wait_retry();
        go_rises = 0;
        send_cmd(1'b0, 1'b1, 2'b10, 32'h0, 8'd3);
        for (int i = 0; i < 4; i++) engine(3'b010, 32'h1111_2222, 1'b0, 1'b0);
        vecs++;
        if (go_rises !== 4) begin
            errs++;
            $display("FAIL wait_gos: got %0d required 4", go_rises);
        end
        vecs++;
        if ({res_valid, res_status, res_ack, res_tries, res_data} !==
            {1'b1, 3'd1, 3'b010, 8'd3, 32'h0}) begin
            errs++;
            $display("FAIL wait_res: val=%b st=%0d ack=%b tries=%0d data=%h required 1 1 010 3 0",
                     res_valid, res_status, res_ack, res_tries, res_data);
        end
        ack_resp();
    endtask

    task automatic test_fault_noack();
        send_cmd(1'b1, 1'b0, 2'b11, 32'hCAFE_F00D, 8'd2);
        vecs++;
        if ({go, rnw, dwrite} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            errs++;
            $display("FAIL wr_req: go=%b rnw=%b dw=%h required 1 0 cafef00d",
                     go, rnw, dwrite);
        end
        engine(3'b100, 32'h5555_AAAA, 1'b0, 1'b0);
        vecs++;
        if ({res_valid, res_status, res_ack, res_data} !==
            {1'b1, 3'd2, 3'b100, 32'h0}) begin
            errs++;
            $display("FAIL fault_res: val=%b st=%0d ack=%b data=%h required 1 2 100 0",
                     res_valid, res_status, res_ack, res_data);
        end
        ack_resp();
        send_cmd(1'b0, 1'b1, 2'b00, 32'h0, 8'd2);
        engine(3'b111, 32'h1234_0000, 1'b0, 1'b0);
        vecs++;
        if ({res_valid, res_status, res_ack, res_data} !==
            {1'b1, 3'd3, 3'b111, 32'h0}) begin
            errs++;
            $display("FAIL noack_res: val=%b st=%0d ack=%b data=%h required 1 3 111 0",
                     res_valid, res_status, res_ack, res_data);
        end
        ack_resp();
    endtask

    task automatic test_timeout();
        int n = 0;
        send_cmd(1'b0, 1'b1, 2'b01, 32'h0, 8'd0);
        while (go && n < 100) begin
            n++;
            tick();
        end
        vecs++;
        if (n !== 16) begin
            errs++;
            $display("FAIL tmo_len: go cycles %0d required 16", n);
        end
        vecs++;
        if ({res_valid, res_status, res_ack} !== {1'b1, 3'd5, 3'b000}) begin
            errs++;
            $display("FAIL tmo_res: val=%b st=%0d ack=%b required 1 5 000",
                     res_valid, res_status, res_ack);
        end
        ack_resp();
    endtask

    task automatic test_perr();
        send_cmd(1'b1, 1'b1, 2'b10, 32'h0, 8'd0);
        engine(3'b001, 32'h0BAD_0BAD, 1'b1, 1'b0);
        vecs++;
        if ({res_valid, res_status, res_data} !== {1'b1, 3'd4, 32'h0BAD_0BAD}) begin
            errs++;
            $display("FAIL perr_res: val=%b st=%0d data=%h required 1 4 0bad0bad",
                     res_valid, res_status, res_data);
        end
        ack_resp();
        perr = 1'b0;
    endtask

    task automatic test_abort_busy();
        go_rises = 0;
        send_cmd(1'b0, 1'b1, 2'b00, 32'h0, 8'd3);
        engine(3'b010, 32'h7777_7777, 1'b0, 1'b1);
        vecs++;
        if ({res_valid, res_status, res_ack, res_tries} !==
            {1'b1, 3'd6, 3'b010, 8'd0} || go_rises !== 1) begin
            errs++;
            $display("FAIL abort_busy: val=%b st=%0d ack=%b tries=%0d gos=%0d required 1 6 010 0 1",
                     res_valid, res_status, res_ack, res_tries, go_rises);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            vecs++;
            if ({res_valid, cmd_ready, res_status, res_ack, res_tries, res_data} !==
                {2'b10, 3'd6, 3'b010, 8'd0, 32'h0}) begin
                errs++;
                $display("FAIL hold_%0d: val=%b rdy=%b st=%0d ack=%b required 1 0 6 010",
                         i, res_valid, cmd_ready, res_status, res_ack);
            end
        end
        ack_resp();
    endtask

    task automatic test_abort_issue();
        send_cmd(1'b0, 1'b0, 2'b01, 32'h0000_00FF, 8'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vecs++;
        if ({go, res_valid, res_status, res_ack} !== {2'b01, 3'd6, 3'b000}) begin
            errs++;
            $display("FAIL abort_issue: go=%b val=%b st=%0d ack=%b required 0 1 6 000",
                     go, res_valid, res_status, res_ack);
        end
        ack_resp();
    endtask

    task automatic test_back_to_back();
        send_cmd(1'b1, 1'b1, 2'b10, 32'h0, 8'd0);
        engine(3'b001, 32'h1234_5678, 1'b0, 1'b0);
        vecs++;
        if ({res_status, res_data} !== {3'd0, 32'h1234_5678}) begin
            errs++;
            $display("FAIL b2b_0: st=%0d data=%h required 0 12345678",
                     res_status, res_data);
        end
        ack_resp();
        send_cmd(1'b1, 1'b1, 2'b11, 32'h0, 8'd0);
        vecs++;
        if ({go, addr32} !== 3'b111) begin
            errs++;
            $display("FAIL b2b_req: go=%b a=%b required 1 11", go, addr32);
        end
        engine(3'b001, 32'hA5A5_0F0F, 1'b0, 1'b0);
        vecs++;
        if ({res_status, res_data} !== {3'd0, 32'hA5A5_0F0F}) begin
            errs++;
            $display("FAIL b2b_1: st=%0d data=%h required 0 a5a50f0f",
                     res_status, res_data);
        end
        ack_resp();
    endtask

    task automatic test_reset_busy();
        int n = 0;
        send_cmd(1'b0, 1'b1, 2'b01, 32'h0, 8'd0);
        idle = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        vecs++;
        if ({go, res_valid, cmd_ready} !== 3'b001) begin
            errs++;
            $display("FAIL rst_busy: go/val/rdy=%b required 001",
                     {go, res_valid, cmd_ready});
        end
        idle = 1'b1;
        tick();
        rst = 1'b1;
        ack = 3'b001;
        repeat (5) begin
            tick();
            if (res_valid) n++;
        end
        vecs++;
        if (n !== 0 || cmd_ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_nores: res cycles %0d rdy=%b required 0 1",
                     n, cmd_ready);
        end
    endtask

    initial begin
        repeat (3) tick();
        test_reset();
        rst = 1'b1;
        tick();
        test_read_ok();
        test_wait_retry();
        test_fault_noack();
        test_timeout();
        test_perr();
        test_abort_busy();
        test_abort_issue();
        test_back_to_back();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
